pwm_duty_ramp: RTL
==================

Name: pwm_duty_ramp

Overview:
- Slew-rate limiter between the SPI register file and the PWM peripheral.
- Takes the duty-cycle byte written over SPI as a target.
- Moves its registered output toward that target by a bounded step once per prescaler period, so a large SPI write cannot slam the outputs from 0x00 to 0xFF in one PWM cycle.
- Output drives pwm_duty_cycle of the PWM peripheral; bypass mode passes the target through with one cycle of latency.

Parameters:
- STEP_DIV, 1000: clock cycles per ramp step (tick period); legal range 1..65535.
- DIV_W, 16: prescaler counter width; must hold STEP_DIV-1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- target_duty  input  8  requested duty cycle from SPI register (0x00 = 0%, 0xFF = 100%)
- ramp_en  input  1  1 = slew-limited ramp, 0 = bypass
- step_size  input  4  duty increment per tick; 0 is treated as 1
- duty_out  output  8  registered duty cycle to PWM peripheral
- busy  output  1  high while ramping (ramp_en=1 and duty_out != target_duty)
- done  output  1  one-cycle pulse when a ramp step lands exactly on target

Behaviour:
- Reset (rst=1 at a clk edge): duty_out=0x00, prescaler=0, done=0. busy then follows its combinational definition.
- Reset mid-ramp aborts immediately: duty_out=0x00 the cycle after, and no done pulse.
- busy is combinational: ramp_en && (duty_out != target_duty).
- Bypass (ramp_en=0):
  - duty_out <= target_duty every cycle (1-cycle latency).
  - Prescaler held at 0; done=0.
- Ramp prescaler (ramp_en=1):
  - When busy=0, prescaler held at 0.
  - When busy=1, prescaler increments each cycle. tick asserts when prescaler==STEP_DIV-1, and the prescaler wraps to 0 on the same edge.
  - The first step therefore lands STEP_DIV cycles after busy rises.
  - STEP_DIV=1 gives a tick every busy cycle.
- Step on tick:
  - Effective step s = (step_size==0) ? 1 : step_size.
  - If duty_out < target: duty_out <= duty_out + min(s, target - duty_out).
  - If duty_out > target: duty_out <= duty_out - min(s, duty_out - target).
  - Compute with 9-bit intermediates. No overshoot, no wrap past 0x00 or 0xFF.
- done:
  - Registered; asserts for exactly one cycle, on the edge where a tick step makes duty_out equal to target_duty as sampled at that edge.
  - No done if equality arises because the target moved onto duty_out.
- Target change mid-ramp:
  - Ramp continues from the current duty_out toward the new target.
  - Prescaler is NOT reset, so the next step comes at the next natural tick.
  - A direction reversal is allowed on that tick.
- Target equals duty_out with no tick pending: busy=0 and the prescaler clears to 0 on the next edge.
- ramp_en 1->0 mid-ramp: duty_out jumps to target the next cycle, prescaler cleared, no done.
- ramp_en 0->1: duty_out already equals target, so idle until the target changes.
- step_size change mid-ramp takes effect at the next tick.
- No combinational path from inputs to duty_out or done; busy is the only combinational output.

Test Plan:
1. STEP_DIV=4. Reset, then target=0x10, ramp_en=1, step=4 -> duty_out 0x04/0x08/0x0C/0x10 at cycles 4/8/12/16 after target set. done high for 1 cycle with duty_out=0x10; busy falls the same edge.
2. STEP_DIV=4, duty_out=0xFD, target=0xFF, step=15 -> single tick lands exactly 0xFF (no wrap); done pulses once. Then target=0x00, step=0 -> decrements by 1 per 4 cycles, with 0xFE at the first tick.
3. Bypass: ramp_en=0, target 0x00->0xAB -> duty_out=0xAB one cycle later; busy=0 and done=0 throughout.
4. Mid-ramp reversal: ramping up at 0x40 toward 0x80, step=8; change target to 0x30 two cycles before a tick -> next tick gives 0x38, following tick 0x30 with done; prescaler phase unchanged.
5. Reset mid-ramp: assert rst for 1 cycle while busy -> duty_out=0x00 the cycle after, done never pulses, prescaler restarts from 0 (next step STEP_DIV cycles after rst deasserts).
6. ramp_en dropped mid-ramp at duty_out=0x20 with target=0x90 -> duty_out=0x90 next cycle, done=0. Re-enable ramp_en -> busy stays 0.

Source files
------------

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slew-rate limiter between the SPI duty-cycle register and
// the PWM peripheral. duty_out walks toward target_duty by at most one
// step_size increment per prescaler period, so a large SPI write cannot
// slam the PWM outputs from 0x00 to 0xFF in one PWM cycle. With ramp_en
// low the target passes straight through with one cycle of latency.
module pwm_duty_ramp #(
   parameter int STEP_DIV = 1000,
   parameter int DIV_W    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] target_duty,
   input  logic       ramp_en,
   input  logic [3:0] step_size,
   output logic [7:0] duty_out,
   output logic       busy,
   output logic       done
);

   localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(STEP_DIV - 1);
   localparam logic [DIV_W-1:0] PRESC_ONE  = DIV_W'(1);

   logic [DIV_W-1:0] presc_q, presc_d;
   logic [7:0]       duty_q, duty_d;
   logic             done_q, done_d;

   logic             busyNow;
   logic             tick;
   logic [8:0]       stepEff;
   logic [8:0]       sumUp;
   logic [8:0]       diffDown;
   logic [7:0]       steppedUp;
   logic [7:0]       steppedDown;
   logic [7:0]       stepped;

   assign busyNow = ramp_en && (duty_q != target_duty);
   assign tick    = busyNow && (presc_q == PRESC_LAST);

   // Candidate next duty for a tick, clamped at target so the ramp never
   // overshoots and the 9-bit intermediates never wrap past 0x00/0xFF.
   always_comb begin
      stepEff     = (step_size == 4'd0) ? 9'd1 : {5'd0, step_size};
      sumUp       = {1'b0, duty_q} + stepEff;
      diffDown    = {1'b0, duty_q} - stepEff;
      steppedUp   = (sumUp > {1'b0, target_duty}) ? target_duty : sumUp[7:0];
      steppedDown = (diffDown[8] || (diffDown[7:0] < target_duty))
                    ? target_duty : diffDown[7:0];
      stepped     = (duty_q < target_duty) ? steppedUp : steppedDown;
   end

   // Prescaler runs only while a ramp is outstanding and wraps on the tick;
   // a target change mid-ramp deliberately keeps the current phase.
   always_comb begin
      presc_d = '0;
      if (busyNow) begin
         if (tick) begin
            presc_d = '0;
         end else begin
            presc_d = presc_q + PRESC_ONE;
         end
      end
   end

   // Next duty and done: bypass copies the target, ramp moves only on tick,
   // and done flags a tick that lands exactly on the current target.
   always_comb begin
      duty_d = duty_q;
      done_d = 1'b0;
      if (!ramp_en) begin
         duty_d = target_duty;
      end else if (tick) begin
         duty_d = stepped;
         done_d = (stepped == target_duty);
      end
   end

   // State registers with synchronous reset; reset aborts any ramp at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         duty_q  <= 8'h00;
         done_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         duty_q  <= duty_d;
         done_q  <= done_d;
      end
   end

   assign duty_out = duty_q;
   assign done     = done_q;
   assign busy     = busyNow;

endmodule
